// File: rtl/huff_sym_decode.sv
// Huffman symbol decoder: collects a left-justified window of stream bits,
// looks it up in the code table, emits the symbol and drops the code bits.
module huff_sym_decode #(
  parameter int HUFF_CODE_LEN = 8,
  parameter int HUFF_LEN_LEN  = $clog2(HUFF_CODE_LEN + 1),
  parameter int SYM_W         = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic                     in_bit,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     tbl_rd,
  output logic [HUFF_CODE_LEN-1:0] tbl_addr,
  input  logic [SYM_W-1:0]         tbl_sym,
  input  logic [HUFF_LEN_LEN-1:0]  tbl_len,
  output logic                     sym_valid,
  output logic [SYM_W-1:0]         sym_data,
  output logic [HUFF_LEN_LEN-1:0]  sym_len,
  input  logic                     sym_ready,
  output logic                     done,
  output logic                     err
);

  localparam logic [2:0] S_FILL   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_OUT    = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  localparam logic [HUFF_LEN_LEN-1:0] FULL = HUFF_LEN_LEN'(HUFF_CODE_LEN);

  logic [2:0]               state, state_nx;
  logic [HUFF_CODE_LEN-1:0] win, win_nx;
  logic [HUFF_LEN_LEN-1:0]  cnt, cnt_nx;
  logic                     flush_seen, flush_seen_nx;
  logic [SYM_W-1:0]         sym_data_nx;
  logic [HUFF_LEN_LEN-1:0]  sym_len_nx;
  logic                     in_ready_nx, done_nx;
  logic                     bit_take;
  logic [HUFF_CODE_LEN-1:0] bit_mask;

  assign bit_take = in_valid & in_ready;
  // New bit lands just below the valid bits; everything under cnt is zero.
  assign bit_mask = {in_bit, {(HUFF_CODE_LEN-1){1'b0}}} >> cnt;

  assign tbl_rd    = (state == S_LOOKUP);
  assign tbl_addr  = win;
  assign sym_valid = (state == S_OUT);
  assign err       = (state == S_ERR);

  always_comb begin
    state_nx      = state;
    win_nx        = win;
    cnt_nx        = cnt;
    flush_seen_nx = flush_seen;
    sym_data_nx   = sym_data;
    sym_len_nx    = sym_len;
    if (start) begin
      state_nx      = S_FILL;
      win_nx        = '0;
      cnt_nx        = '0;
      flush_seen_nx = 1'b0;
    end else begin
      if (flush && state != S_ERR) flush_seen_nx = 1'b1;
      case (state)
        S_FILL: begin
          if (bit_take) begin
            win_nx = win | bit_mask;
            cnt_nx = cnt + 1'b1;
          end
          if (cnt == FULL || (flush_seen && cnt != '0)) state_nx = S_LOOKUP;
        end
        S_LOOKUP: state_nx = S_WAIT;
        S_WAIT: begin
          // A code longer than the remaining bits can only mean a truncated stream.
          if (tbl_len == '0 || tbl_len > cnt) begin
            state_nx = S_ERR;
          end else begin
            sym_data_nx = tbl_sym;
            sym_len_nx  = tbl_len;
            state_nx    = S_OUT;
          end
        end
        S_OUT: begin
          if (sym_ready) begin
            win_nx   = win << sym_len;
            cnt_nx   = cnt - sym_len;
            state_nx = S_FILL;
          end
        end
        S_ERR:   state_nx = S_ERR;
        default: state_nx = S_FILL;
      endcase
    end
    in_ready_nx = (state_nx == S_FILL) && (cnt_nx < FULL) && !flush_seen_nx;
    done_nx     = (state_nx == S_FILL) && flush_seen_nx && (cnt_nx == '0);
  end

  // in_ready and done are registered so every output is 0 while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FILL;
      win        <= '0;
      cnt        <= '0;
      flush_seen <= 1'b0;
      sym_data   <= '0;
      sym_len    <= '0;
      in_ready   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      win        <= win_nx;
      cnt        <= cnt_nx;
      flush_seen <= flush_seen_nx;
      sym_data   <= sym_data_nx;
      sym_len    <= sym_len_nx;
      in_ready   <= in_ready_nx;
      done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_huff_sym_decode.sv
// Directed bench for huff_sym_decode with a small behavioural code table.
module tb_huff_sym_decode;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, in_valid, in_bit, in_ready, flush;
  logic       tbl_rd;
  logic [7:0] tbl_addr;
  logic [8:0] tbl_sym;
  logic [3:0] tbl_len;
  logic       sym_valid;
  logic [8:0] sym_data;
  logic [3:0] sym_len;
  logic       sym_ready, done, err;

  int checks   = 0;
  int failures = 0;
  int tbl_mode = 0;

  huff_sym_decode dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_bit(in_bit), .in_ready(in_ready), .flush(flush), .tbl_rd(tbl_rd),
    .tbl_addr(tbl_addr), .tbl_sym(tbl_sym), .tbl_len(tbl_len),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_len(sym_len),
    .sym_ready(sym_ready), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Table contents per test: returns {sym, len}.
  function automatic logic [12:0] tableEntry(input int mode, input logic [7:0] a);
    tableEntry = {9'd0, 4'd0};
    case (mode)
      0: if (a[7] == 1'b0) tableEntry = {9'd65, 4'd1};
         else if (a[7:6] == 2'b10) tableEntry = {9'd66, 4'd2};
      1: if (a == 8'b10100000) tableEntry = {9'd7, 4'd3};
      3: tableEntry = {9'd9, 4'd4};
      default: tableEntry = {9'd0, 4'd0};
    endcase
  endfunction

  always @(posedge clk) begin
    if (tbl_rd) {tbl_sym, tbl_len} <= tableEntry(tbl_mode, tbl_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    stepCycle();
    in_valid = 1'b0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    stepCycle();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; in_valid = 0; in_bit = 0; flush = 0; sym_ready = 0;
    tbl_sym = '0; tbl_len = '0;
    stepCycle(); stepCycle();
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_tbl_rd", tbl_rd, 0);
    checkOutput("rst_sym_valid", sym_valid, 0);
    checkOutput("rst_done_err", {done, err}, 0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("post_rst_in_ready", in_ready, 1);

    // Two symbols from 0,1,0,1,...
    tbl_mode = 0;
    for (int i = 0; i < 8; i++) applyStimulus(i[0]);
    checkOutput("full_in_ready", in_ready, 0);
    stepCycle();
    checkOutput("t1_tbl_rd", tbl_rd, 1);
    checkOutput("t1_tbl_addr", tbl_addr, 8'h55);
    stepCycle();
    checkOutput("t1_tbl_rd_single", tbl_rd, 0);
    checkOutput("t1_wait_valid", sym_valid, 0);
    stepCycle();
    checkOutput("t1_sym_valid", sym_valid, 1);
    checkOutput("t1_sym_data", sym_data, 65);
    checkOutput("t1_sym_len", sym_len, 1);
    sym_ready = 1'b1;
    stepCycle();
    sym_ready = 1'b0;
    checkOutput("t1_valid_fall", sym_valid, 0);
    checkOutput("t1_shift_addr", tbl_addr, 8'hAA);
    checkOutput("t1_refill_ready", in_ready, 1);
    applyStimulus(1'b0);
    checkOutput("t1_refill1_full", in_ready, 0);
    stepCycle();
    checkOutput("t1b_tbl_rd", tbl_rd, 1);
    checkOutput("t1b_tbl_addr", tbl_addr, 8'hAA);
    stepCycle(); stepCycle();
    checkOutput("t1b_sym_valid", sym_valid, 1);
    checkOutput("t1b_sym_data", sym_data, 66);
    checkOutput("t1b_sym_len", sym_len, 2);

    // Backpressure: output held, stray bits ignored
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_bit = 1'b1;
      stepCycle();
      checkOutput("bp_valid", sym_valid, 1);
      checkOutput("bp_data_len", {sym_data, sym_len}, {9'd66, 4'd2});
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_window", tbl_addr, 8'hAA);
    end
    in_valid = 1'b0;
    sym_ready = 1'b1;
    stepCycle();
    sym_ready = 1'b0;
    checkOutput("bp_consume_addr", tbl_addr, 8'hA8);
    checkOutput("bp_consume_valid", sym_valid, 0);
    applyStimulus(1'b1);
    checkOutput("bp_refill_addr", tbl_addr, 8'hAA);
    checkOutput("bp_refill2_ready", in_ready, 1);

    // Flush with three bits left
    pulseStart();
    checkOutput("st_addr", tbl_addr, 0);
    checkOutput("st_ready", in_ready, 1);
    tbl_mode = 1;
    applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b1);
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    checkOutput("fl_in_ready", in_ready, 0);
    checkOutput("fl_done_early", done, 0);
    stepCycle();
    checkOutput("fl_tbl_rd", tbl_rd, 1);
    checkOutput("fl_tbl_addr", tbl_addr, 8'hA0);
    stepCycle(); stepCycle();
    checkOutput("fl_sym_valid", sym_valid, 1);
    checkOutput("fl_sym", {sym_data, sym_len}, {9'd7, 4'd3});
    sym_ready = 1'b1;
    stepCycle();
    sym_ready = 1'b0;
    checkOutput("fl_done", done, 1);
    checkOutput("fl_addr_empty", tbl_addr, 0);
    checkOutput("fl_ready_after", in_ready, 0);
    stepCycle();
    checkOutput("fl_done_hold", done, 1);
    checkOutput("fl_no_lookup", tbl_rd, 0);

    // Flush on empty window
    pulseStart();
    checkOutput("fe_done_cleared", done, 0);
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    checkOutput("fe_done", done, 1);
    stepCycle();
    checkOutput("fe_no_lookup", tbl_rd, 0);

    // Unused table entry
    pulseStart();
    tbl_mode = 2;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1);
    stepCycle();
    checkOutput("e0_tbl_rd", tbl_rd, 1);
    stepCycle();
    checkOutput("e0_err_wait", err, 0);
    stepCycle();
    checkOutput("e0_err", err, 1);
    checkOutput("e0_valid", sym_valid, 0);
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    stepCycle();
    checkOutput("e0_err_sticky", err, 1);
    checkOutput("e0_no_done", done, 0);
    checkOutput("e0_ready", in_ready, 0);
    pulseStart();
    checkOutput("e0_clear_err", err, 0);
    checkOutput("e0_clear_ready", in_ready, 1);

    // Truncated stream: two bits, code length 4
    tbl_mode = 3;
    applyStimulus(1'b1); applyStimulus(1'b1);
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    stepCycle();
    checkOutput("tr_tbl_addr", tbl_addr, 8'hC0);
    stepCycle(); stepCycle();
    checkOutput("tr_err", err, 1);
    checkOutput("tr_valid", sym_valid, 0);

    // start during OUT, then reset during WAIT
    pulseStart();
    tbl_mode = 0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0);
    stepCycle(); stepCycle(); stepCycle();
    checkOutput("so_valid", sym_valid, 1);
    checkOutput("so_data", sym_data, 65);
    pulseStart();
    checkOutput("so_valid_drop", sym_valid, 0);
    checkOutput("so_addr", tbl_addr, 0);
    checkOutput("so_ready", in_ready, 1);
    applyStimulus(1'b1);
    checkOutput("so_cnt_zero", tbl_addr, 8'h80);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0);
    stepCycle();
    checkOutput("rw_tbl_rd", tbl_rd, 1);
    stepCycle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rw_addr", tbl_addr, 0);
    checkOutput("rw_sym", {sym_data, sym_len}, 0);
    checkOutput("rw_flags", {in_ready, tbl_rd, sym_valid, done, err}, 0);
    stepCycle();
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
